instr_mem_loader: RTL and testbench

//  Write-side companion to the instruction memory. Accepts a program as a byte

---
 rtl/instr_mem_loader.sv | 109 ++++++++++
 tb/tb_instr_mem_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Packs a valid/ready byte stream MSB-first into 32-bit words and writes them to consecutive instruction-memory addresses.
// Latency: write strobe in the cycle after the 4th byte of a word is accepted. Throughput is at most one word per 5 cycles.
// Backpressure: byte_ready is high only in LOAD, so bytes offered in IDLE, WRITE or DONE are left unconsumed.
module instr_mem_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    state_t          state;
    state_t          state_nxt;
    logic [ADDR_W:0] len;
    logic [ADDR_W:0] len_clamped;
    logic [ADDR_W:0] count_inc;
    logic [1:0]      byte_idx;
    logic [23:0]     word;

    assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign count_inc   = word_count + ONE_L;

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        wr_en      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len_clamped == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && byte_idx == 2'd3) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                wr_en     = 1'b1;
                busy      = 1'b1;
                state_nxt = (count_inc == len) ? DONE : LOAD;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Only the first three bytes need storage; the fourth goes straight into wr_data,
    // which then holds until the next word completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            len        <= '0;
            byte_idx   <= 2'd0;
            word       <= '0;
            word_count <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        len        <= len_clamped;
                        word_count <= '0;
                        byte_idx   <= 2'd0;
                        word       <= '0;
                    end
                end
                LOAD: begin
                    if (byte_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        word     <= {word[15:0], byte_in};
                        if (byte_idx == 2'd3) begin
                            wr_data <= {word, byte_in};
                            wr_addr <= word_count[ADDR_W-1:0];
                        end
                    end
                end
                WRITE: word_count <= count_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader: a transaction-level byte/word model checked every cycle, plus literal expectations.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  prog_len = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [5:0]  word_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    instr_mem_loader #(.ADDR_W(5), .DEPTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .prog_len(prog_len),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Reference model: a load is a sequence of 4-byte groups; each completed group
    // produces one write cycle, and the last write is followed by one done cycle.
    bit          m_active = 0;
    bit          m_wr = 0;
    bit          m_done = 0;
    int          m_len = 0;
    logic [5:0]  m_cnt = '0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    logic [7:0]  q[$];

    always @(posedge clk) begin
        if (reset) begin
            m_active = 0; m_wr = 0; m_done = 0; m_len = 0;
            m_cnt = '0; m_waddr = '0; m_wdata = '0; q.delete();
        end else if (m_wr) begin
            m_wr  = 0;
            m_cnt = m_cnt + 6'd1;
            if (int'(m_cnt) == m_len) m_done = 1;
            else m_active = 1;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (byte_valid) begin
                q.push_back(byte_in);
                if (q.size() == 4) begin
                    m_wdata  = {q[0], q[1], q[2], q[3]};
                    m_waddr  = m_cnt[4:0];
                    q.delete();
                    m_active = 0;
                    m_wr     = 1;
                end
            end
        end else if (start) begin
            m_len = (int'(prog_len) > 32) ? 32 : int'(prog_len);
            m_cnt = '0;
            q.delete();
            if (m_len == 0) m_done = 1;
            else m_active = 1;
        end
    end

    logic [4:0]  log_addr[$];
    logic [31:0] log_data[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({byte_ready, wr_en, busy, done} !== {m_active, m_wr, m_active | m_wr, m_done} ||
                word_count !== m_cnt || wr_addr !== m_waddr || wr_data !== m_wdata) begin
                errors++;
                $display("FAIL cycle t=%0t got rdy=%b wr=%b busy=%b done=%b cnt=%0d addr=%0d data=%h want rdy=%b wr=%b busy=%b done=%b cnt=%0d addr=%0d data=%h",
                         $time, byte_ready, wr_en, busy, done, word_count, wr_addr, wr_data,
                         m_active, m_wr, m_active | m_wr, m_done, m_cnt, m_waddr, m_wdata);
            end
            if (wr_en === 1'b1) begin
                log_addr.push_back(wr_addr);
                log_data.push_back(wr_data);
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [5:0] len);
        prog_len = len;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        prog_len = 6'($urandom_range(0, 63));
    endtask

    // Offer one byte, idling 'gap' cycles first with junk on byte_in.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int i = 0; i < gap; i++) begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_in    = b;
        t = 0;
        @(negedge clk);
        while (byte_ready !== 1'b1 && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (t >= 200) begin
            errors++;
            $display("FAIL byte_ready_timeout got 0 want 1");
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
    endtask

    task automatic wait_done();
        int t = 0;
        @(negedge clk);
        while (done !== 1'b1 && t < 2000) begin
            t++;
            @(negedge clk);
        end
        if (t >= 2000) begin
            errors++;
            $display("FAIL done_timeout got 0 want 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset(input int edges);
        reset = 1'b1;
        repeat (edges) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_outputs", {byte_ready, wr_en, busy, done, word_count, wr_addr, wr_data}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    logic [7:0] prog[8];

    initial begin
        prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        @(posedge clk); #1;
        chk_en = 1;
        apply_reset(2);

        // Reset in the middle of a stream: valid held high through reset, no write.
        clear_log();
        do_start(6'd3);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
        byte_valid = 1'b1;
        byte_in    = 8'hAA;
        apply_reset(2);
        byte_valid = 1'b0;
        check("midreset_writes", 64'(log_addr.size()), 64'd1);
        check("midreset_cnt", 64'(word_count), 64'd0);

        // Back-to-back two-word program.
        clear_log();
        do_start(6'd2);
        for (int i = 0; i < 8; i++) send_byte(prog[i], 0);
        wait_done();
        check("b2b_nwr", 64'(log_addr.size()), 64'd2);
        if (log_addr.size() == 2) begin
            check("b2b_addr0", 64'(log_addr[0]), 64'd0);
            check("b2b_data0", 64'(log_data[0]), 64'h20080005);
            check("b2b_addr1", 64'(log_addr[1]), 64'd1);
            check("b2b_data1", 64'(log_data[1]), 64'h8C090004);
        end
        check("b2b_done", 64'(done_cnt), 64'd1);
        check("b2b_count", 64'(word_count), 64'd2);

        // Same program with a bubble before every byte.
        clear_log();
        do_start(6'd2);
        for (int i = 0; i < 8; i++) send_byte(prog[i], 1);
        wait_done();
        check("gap_nwr", 64'(log_addr.size()), 64'd2);
        if (log_data.size() == 2) begin
            check("gap_data0", 64'(log_data[0]), 64'h20080005);
            check("gap_data1", 64'(log_data[1]), 64'h8C090004);
        end

        // Zero-length program: done in the cycle after start is taken.
        clear_log();
        do_start(6'd0);
        @(negedge clk);
        check("zero_done", 64'(done), 64'd1);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        check("zero_nwr", 64'(log_addr.size()), 64'd0);
        check("zero_cnt", 64'(word_count), 64'd0);

        // Over-long program is clamped to 32 words.
        clear_log();
        do_start(6'd40);
        for (int i = 0; i < 32 * 4; i++) send_byte(8'($urandom), 0);
        wait_done();
        check("clamp_nwr", 64'(log_addr.size()), 64'd32);
        if (log_addr.size() == 32) begin
            check("clamp_first", 64'(log_addr[0]), 64'd0);
            check("clamp_last", 64'(log_addr[31]), 64'd31);
        end
        check("clamp_done", 64'(done_cnt), 64'd1);
        check("clamp_cnt", 64'(word_count), 64'd32);

        // start during LOAD is ignored; reset after 2 bytes aborts; fresh load is clean.
        clear_log();
        do_start(6'd2);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        prog_len = 6'd1;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        check("start_in_load_busy", 64'(busy), 64'd1);
        apply_reset(2);
        check("abort_nwr", 64'(log_addr.size()), 64'd0);
        do_start(6'd1);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 1);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 2);
        wait_done();
        check("fresh_nwr", 64'(log_addr.size()), 64'd1);
        if (log_data.size() == 1) begin
            check("fresh_addr", 64'(log_addr[0]), 64'd0);
            check("fresh_data", 64'(log_data[0]), 64'hDEADBEEF);
        end

        // Randomized loads: lengths, bytes and bubbles drawn at random.
        for (int n = 0; n < 6; n++) begin
            int len;
            int words;
            clear_log();
            len   = $urandom_range(0, 40);
            words = (len > 32) ? 32 : len;
            do_start(6'(len));
            for (int i = 0; i < words * 4; i++) send_byte(8'($urandom), $urandom_range(0, 2));
            wait_done();
            check("rand_nwr", 64'(log_addr.size()), 64'(words));
        end

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
